// File: rtl/reclock_cm.sv
// Output relatch for attacker-facing lines: synchronises DIN, then bypasses, relatches,
// delays each edge by an LFSR-chosen number of cycles, or freezes the outputs.
module reclock_cm #(
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned JIT_BITS    = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          MODE,
    input  logic [CHANNELS-1:0] DIN,
    output logic [CHANNELS-1:0] DOUT,
    output logic [CHANNELS-1:0] BUSY,
    output logic [15:0]         EDGE_CNT
);

    typedef enum logic [1:0] {
        ModeBypass  = 2'b00,
        ModeRelatch = 2'b01,
        ModeJitter  = 2'b10,
        ModeFreeze  = 2'b11
    } mode_e;

    typedef enum logic {StIdle, StWait} state_e;

    mode_e mode;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0]                  sync_last;
    logic [CHANNELS-1:0]                  out_q, out_d;
    logic [15:0]                          lfsr_q, lfsr_d;
    logic [15:0]                          edge_cnt_q, edge_cnt_d;
    state_e                               state_q [CHANNELS];
    state_e                               state_d [CHANNELS];
    logic [JIT_BITS-1:0]                  cnt_q   [CHANNELS];
    logic [JIT_BITS-1:0]                  cnt_d   [CHANNELS];

    assign mode      = mode_e'(MODE);
    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = DIN;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q     <= '0;
            out_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            edge_cnt_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= StIdle;
                cnt_q[ch]   <= '0;
            end
        end else begin
            sync_q     <= sync_d;
            out_q      <= out_d;
            lfsr_q     <= lfsr_d;
            edge_cnt_q <= edge_cnt_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Next-state logic
    always_comb begin
        out_d = out_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            state_d[ch] = StIdle;
            cnt_d[ch]   = '0;
            unique case (mode)
                ModeBypass, ModeRelatch: begin
                    out_d[ch] = sync_last[ch];
                end
                ModeFreeze: begin
                end
                ModeJitter: begin
                    unique case (state_q[ch])
                        StIdle: begin
                            if (sync_last[ch] != out_q[ch]) begin
                                if (lfsr_q[ch*JIT_BITS +: JIT_BITS] == '0) begin
                                    out_d[ch] = sync_last[ch];
                                end else begin
                                    cnt_d[ch]   = lfsr_q[ch*JIT_BITS +: JIT_BITS];
                                    state_d[ch] = StWait;
                                end
                            end
                        end
                        StWait: begin
                            cnt_d[ch] = cnt_q[ch] - JIT_BITS'(1);
                            // Sample sync at expiry, so short pulses vanish silently
                            if (cnt_q[ch] == JIT_BITS'(1)) begin
                                out_d[ch] = sync_last[ch];
                            end else begin
                                state_d[ch] = StWait;
                            end
                        end
                    endcase
                end
            endcase
        end
        edge_cnt_d = edge_cnt_q + 16'($countones(out_d ^ out_q));
    end

    // Outputs
    always_comb begin
        DOUT     = (mode == ModeBypass) ? DIN : out_q;
        EDGE_CNT = edge_cnt_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            BUSY[ch] = (state_q[ch] == StWait);
        end
    end

endmodule
